// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix-multiply datapath loop-index logic.
//   DEF_INDEX_W : default width of index/limit registers
//   DEF_STEP_W  : default width of the step input
//   WRAP / SAT  : encodings of the wrap_mode input
package matmul_pkg;

  localparam int unsigned DEF_INDEX_W = 8;
  localparam int unsigned DEF_STEP_W  = 4;

  localparam logic WRAP = 1'b1;
  localparam logic SAT  = 1'b0;

endpackage : matmul_pkg

// File: rtl/index_limit_cmp.sv
// Combinational index + step adder with a greater-than-limit compare.
// The add is done in WIDTH+1 bits so a carry past 2**WIDTH reads as over-limit.
//   index_i        : current index
//   step_i         : unsigned increment
//   limit_i        : current limit
//   sum_c_o        : low WIDTH bits of index + step (exact whenever !over_limit_c_o)
//   over_limit_c_o : index + step > limit
module index_limit_cmp #(
  parameter int unsigned WIDTH  = matmul_pkg::DEF_INDEX_W,
  parameter int unsigned STEP_W = matmul_pkg::DEF_STEP_W
) (
  input  logic [WIDTH-1:0]  index_i,
  input  logic [STEP_W-1:0] step_i,
  input  logic [WIDTH-1:0]  limit_i,
  output logic [WIDTH-1:0]  sum_c_o,
  output logic              over_limit_c_o
);

  localparam int unsigned SUM_W = WIDTH + 1;

  logic [SUM_W-1:0] sum_wide;

  assign sum_wide       = SUM_W'(index_i) + SUM_W'(step_i);
  assign sum_c_o        = sum_wide[WIDTH-1:0];
  assign over_limit_c_o = sum_wide > SUM_W'(limit_i);

endmodule : index_limit_cmp

// File: rtl/index_counter_reg.sv
// Loop-index register with programmable step and limit, wrap/saturate mode,
// a registered carry pulse for cascading, and a sticky saturation flag.
//   clk, reset           : clock, async active-low reset
//   clear                : sync clear of index (and sat_flag)
//   load_enable, data_in : load index
//   limit_load, limit_in : load limit register (parallel to index update)
//   inc, step            : advance index by step
//   wrap_mode            : WRAP = wrap to 0 past limit, SAT = clip at limit
//   data_out             : registered index
//   at_limit             : data_out == limit, from registered state only
//   carry_out            : registered one-cycle pulse on wrap
//   sat_flag             : sticky, set when an increment was clipped
module index_counter_reg
  import matmul_pkg::*;
#(
  parameter int unsigned      WIDTH       = DEF_INDEX_W,
  parameter int unsigned      STEP_W      = DEF_STEP_W,
  parameter logic [WIDTH-1:0] RESET_LIMIT = {WIDTH{1'b1}}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              load_enable,
  input  logic [WIDTH-1:0]  data_in,
  input  logic              limit_load,
  input  logic [WIDTH-1:0]  limit_in,
  input  logic              inc,
  input  logic [STEP_W-1:0] step,
  input  logic              wrap_mode,
  output logic [WIDTH-1:0]  data_out,
  output logic              at_limit,
  output logic              carry_out,
  output logic              sat_flag
);

  logic [WIDTH-1:0] index_q, index_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             carry_q, carry_d;
  logic             sat_q,   sat_d;

  logic [WIDTH-1:0] sum;
  logic             over_limit;

  // Always compares against the limit currently held, so a same-cycle
  // limit_load only affects the following cycle.
  index_limit_cmp #(
    .WIDTH  (WIDTH),
    .STEP_W (STEP_W)
  ) u_cmp (
    .index_i        (index_q),
    .step_i         (step),
    .limit_i        (limit_q),
    .sum_c_o        (sum),
    .over_limit_c_o (over_limit)
  );

  // Index / flag next-state: clear > load_enable > inc.
  always_comb begin
    index_d = index_q;
    carry_d = 1'b0;
    sat_d   = sat_q;

    if (clear) begin
      index_d = '0;
      sat_d   = 1'b0;
    end else if (load_enable) begin
      index_d = data_in;
    end else if (inc && (step != '0)) begin
      // step == 0 is a no-op even when the index already exceeds the limit.
      if (!over_limit) begin
        index_d = sum;
      end else if (wrap_mode == WRAP) begin
        index_d = '0;
        carry_d = 1'b1;
      end else begin
        index_d = limit_q;
        sat_d   = 1'b1;
      end
    end
  end

  // Limit update is independent of the index path.
  always_comb begin
    limit_d = limit_q;
    if (limit_load) begin
      limit_d = limit_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      index_q <= '0;
      limit_q <= RESET_LIMIT;
      carry_q <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      index_q <= index_d;
      limit_q <= limit_d;
      carry_q <= carry_d;
      sat_q   <= sat_d;
    end
  end

  assign data_out  = index_q;
  assign carry_out = carry_q;
  assign sat_flag  = sat_q;
  assign at_limit  = (index_q == limit_q);

endmodule : index_counter_reg
